// File: rtl/led_pwm_blinker.sv
// LED driver between the PIO out_port and the pins: global PWM brightness, optional blink, polarity.
// Avalon-MM slave with zero-wait-state combinational reads; led_out is registered (1 cycle).
module led_pwm_blinker #(
  parameter int PRESCALE_W = 16,
  parameter int BLINK_W    = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  input  logic [7:0]  led_in,
  output logic [7:0]  led_out
);

  logic                  enable, blink_en, invert;
  logic [7:0]            duty_reg;
  logic [PRESCALE_W-1:0] prescale_reg;
  logic [BLINK_W-1:0]    blink_reg;

  logic [PRESCALE_W-1:0] pc;
  logic [7:0]            pwm_cnt;
  logic [7:0]            duty_act;
  logic [BLINK_W-1:0]    blink_cnt;
  logic                  blink_phase;

  logic wr, wr_ctrl, wr_duty, wr_prescale, wr_blink;
  logic tick, frame_end, pwm_on, blink_wrap, load_duty;
  logic unused_wdata;

  assign wr          = chipselect & ~write_n;
  assign wr_ctrl     = wr & (address == 2'd0);
  assign wr_duty     = wr & (address == 2'd1);
  assign wr_prescale = wr & (address == 2'd2);
  assign wr_blink    = wr & (address == 2'd3);
  assign unused_wdata = ^writedata;

  assign tick       = enable & (pc == prescale_reg);
  assign frame_end  = tick & (pwm_cnt == 8'hFF);
  assign pwm_on     = (duty_act == 8'hFF) | (pwm_cnt < duty_act);
  assign blink_wrap = frame_end & (blink_cnt == blink_reg);
  assign load_duty  = frame_end | ~enable;

  always_comb begin
    readdata = 32'd0;
    case (address)
      2'd0:    readdata = {23'd0, blink_phase, 5'd0, invert, blink_en, enable};
      2'd1:    readdata = {24'd0, duty_reg};
      2'd2:    readdata = {{(32-PRESCALE_W){1'b0}}, prescale_reg};
      default: readdata = {{(32-BLINK_W){1'b0}}, blink_reg};
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      enable       <= 1'b0;
      blink_en     <= 1'b0;
      invert       <= 1'b0;
      duty_reg     <= 8'hFF;
      prescale_reg <= '0;
      blink_reg    <= '0;
    end else begin
      if (wr_ctrl)     {invert, blink_en, enable} <= writedata[2:0];
      if (wr_duty)     duty_reg     <= writedata[7:0];
      if (wr_prescale) prescale_reg <= writedata[PRESCALE_W-1:0];
      if (wr_blink)    blink_reg    <= writedata[BLINK_W-1:0];
    end
  end

  // Timebase: prescaler feeds the 8-bit PWM frame counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc      <= '0;
      pwm_cnt <= 8'd0;
    end else if (!enable) begin
      pc      <= '0;
      pwm_cnt <= 8'd0;
    end else begin
      if (wr_prescale || tick) pc <= '0;
      else                     pc <= pc + 1'b1;
      if (tick) pwm_cnt <= pwm_cnt + 8'd1;
    end
  end

  // Shadow only updates between frames; a DUTY write landing on the frame boundary wins.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)       duty_act <= 8'hFF;
    else if (load_duty) duty_act <= wr_duty ? writedata[7:0] : duty_reg;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b1;
    end else if (!enable || !blink_en) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b1;
    end else begin
      if (blink_wrap)                 blink_phase <= ~blink_phase;
      if (wr_blink || blink_wrap)     blink_cnt   <= '0;
      else if (frame_end)             blink_cnt   <= blink_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)     led_out <= 8'h00;
    else if (!enable) led_out <= led_in ^ {8{invert}};
    else              led_out <= (led_in & {8{pwm_on & blink_phase}}) ^ {8{invert}};
  end

endmodule

// File: tb/tb_led_pwm_blinker.sv
// Bench for led_pwm_blinker: expected values queued per scenario, compared against captured led_out / reads.
module tb_led_pwm_blinker;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [7:0]  led_in;
  logic [7:0]  led_out;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_q[$];
  logic [7:0]  cap[0:3199];
  int          cap_n;

  led_pwm_blinker #(.PRESCALE_W(16), .BLINK_W(8)) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .led_in(led_in), .led_out(led_out)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic reg_write(input logic [1:0] a, input logic [31:0] d);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    step();
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic reg_read(input logic [1:0] a, output logic [31:0] d);
    address = a;
    #1;
    d = readdata;
  endtask

  // Sample n cycles of led_out into cap[], optionally issuing one write on the edge of sample wr_at.
  task automatic capture(input int n, input int wr_at, input logic [1:0] a, input logic [31:0] d);
    for (int i = 1; i <= n; i++) begin
      if (i == wr_at) begin
        address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
      end
      step();
      chipselect = 1'b0; write_n = 1'b1;
      cap_n++;
      cap[cap_n] = led_out;
    end
  endtask

  task automatic restart(input logic [31:0] ctrl);
    reg_write(2'd0, 32'd0);
    reg_write(2'd0, ctrl);
    cap_n = 0;
  endtask

  function automatic logic [31:0] count_eq(input int lo, input int hi, input logic [7:0] v);
    logic [31:0] c = 0;
    for (int i = lo; i <= hi; i++) if (cap[i] === v) c++;
    return c;
  endfunction

  task automatic test_reset();
    logic [31:0] obs[$];
    string       nm[$];
    logic [31:0] r, o, e;
    string       n;
    reset_n = 1'b0; led_in = 8'h00; address = 2'd0; chipselect = 1'b0; write_n = 1'b1; writedata = 32'd0;
    step(); step();
    reset_n = 1'b1;
    step();
    reg_write(2'd0, 32'h4);
    reg_write(2'd1, 32'h12);
    reg_write(2'd2, 32'h5);
    reg_write(2'd3, 32'h9);
    step(); step();
    exp_q.push_back(32'hFF); obs.push_back({24'd0, led_out}); nm.push_back("pre_reset_led");
    #2 reset_n = 1'b0;
    #1;
    exp_q.push_back(32'h00); obs.push_back({24'd0, led_out}); nm.push_back("reset_led");
    step(); step();
    reset_n = 1'b1;
    exp_q.push_back(32'h100); reg_read(2'd0, r); obs.push_back(r); nm.push_back("reset_ctrl");
    exp_q.push_back(32'hFF);  reg_read(2'd1, r); obs.push_back(r); nm.push_back("reset_duty");
    exp_q.push_back(32'h0);   reg_read(2'd2, r); obs.push_back(r); nm.push_back("reset_prescale");
    exp_q.push_back(32'h0);   reg_read(2'd3, r); obs.push_back(r); nm.push_back("reset_blink");
    while (obs.size() > 0) begin
      o = obs.pop_front(); e = exp_q.pop_front(); n = nm.pop_front();
      checks++;
      if (o !== e) begin errors++; $display("FAIL %s got %0h want %0h", n, o, e); end
    end
  endtask

  task automatic test_passthrough();
    logic [31:0] e;
    led_in = 8'hA5;
    exp_q.push_back(32'hA5);
    step();
    e = exp_q.pop_front(); checks++;
    if ({24'd0, led_out} !== e) begin errors++; $display("FAIL pass_a5 got %0h want %0h", led_out, e); end
    reg_write(2'd0, 32'h4);
    exp_q.push_back(32'h5A);
    step();
    e = exp_q.pop_front(); checks++;
    if ({24'd0, led_out} !== e) begin errors++; $display("FAIL pass_invert got %0h want %0h", led_out, e); end
  endtask

  task automatic test_pwm();
    logic [31:0] obs[$];
    string       nm[$];
    logic [31:0] o, e;
    string       n;
    led_in = 8'hFF;
    reg_write(2'd2, 32'd0);
    reg_write(2'd1, 32'd64);
    restart(32'h1);
    exp_q.push_back(32'd64); exp_q.push_back(32'd64);
    exp_q.push_back(32'hFF); exp_q.push_back(32'hFF); exp_q.push_back(32'h00);
    exp_q.push_back(32'h00); exp_q.push_back(32'hFF);
    capture(520, 0, 2'd0, 32'd0);
    obs.push_back(count_eq(1, 256, 8'hFF));   nm.push_back("pwm64_frame1_on");
    obs.push_back(count_eq(257, 512, 8'hFF)); nm.push_back("pwm64_frame2_on");
    obs.push_back({24'd0, cap[1]});   nm.push_back("pwm64_first");
    obs.push_back({24'd0, cap[64]});  nm.push_back("pwm64_last_on");
    obs.push_back({24'd0, cap[65]});  nm.push_back("pwm64_first_off");
    obs.push_back({24'd0, cap[256]}); nm.push_back("pwm64_frame_tail");
    obs.push_back({24'd0, cap[257]}); nm.push_back("pwm64_period");
    while (obs.size() > 0) begin
      o = obs.pop_front(); e = exp_q.pop_front(); n = nm.pop_front();
      checks++;
      if (o !== e) begin errors++; $display("FAIL %s got %0h want %0h", n, o, e); end
    end
  endtask

  task automatic test_duty_change();
    logic [31:0] obs[$];
    string       nm[$];
    logic [31:0] o, e;
    string       n;
    led_in = 8'hFF;
    reg_write(2'd1, 32'd64);
    restart(32'h1);
    exp_q.push_back(32'd64); exp_q.push_back(32'd200); exp_q.push_back(32'hFF); exp_q.push_back(32'h00);
    capture(600, 11, 2'd1, 32'd200);
    obs.push_back(count_eq(1, 256, 8'hFF));   nm.push_back("duty_mid_frame_on");
    obs.push_back(count_eq(257, 512, 8'hFF)); nm.push_back("duty_next_frame_on");
    obs.push_back({24'd0, cap[456]});         nm.push_back("duty200_last_on");
    obs.push_back({24'd0, cap[457]});         nm.push_back("duty200_first_off");
    while (obs.size() > 0) begin
      o = obs.pop_front(); e = exp_q.pop_front(); n = nm.pop_front();
      checks++;
      if (o !== e) begin errors++; $display("FAIL %s got %0h want %0h", n, o, e); end
    end
  endtask

  task automatic test_extremes();
    logic [31:0] obs[$];
    string       nm[$];
    logic [31:0] o, e;
    string       n;
    led_in = 8'h3C;
    reg_write(2'd1, 32'd0);
    restart(32'h1);
    exp_q.push_back(32'd512);
    capture(512, 0, 2'd0, 32'd0);
    obs.push_back(count_eq(1, 512, 8'h00)); nm.push_back("duty0_dark");
    reg_write(2'd1, 32'd255);
    restart(32'h1);
    exp_q.push_back(32'd512);
    capture(512, 0, 2'd0, 32'd0);
    obs.push_back(count_eq(1, 512, 8'h3C)); nm.push_back("duty255_pass");
    led_in = 8'hFF;
    reg_write(2'd1, 32'd64);
    reg_write(2'd2, 32'd3);
    restart(32'h1);
    exp_q.push_back(32'd256); exp_q.push_back(32'hFF); exp_q.push_back(32'h00); exp_q.push_back(32'hFF);
    capture(1030, 0, 2'd0, 32'd0);
    obs.push_back(count_eq(1, 1024, 8'hFF)); nm.push_back("ps3_frame_on");
    obs.push_back({24'd0, cap[256]});        nm.push_back("ps3_last_on");
    obs.push_back({24'd0, cap[257]});        nm.push_back("ps3_first_off");
    obs.push_back({24'd0, cap[1025]});       nm.push_back("ps3_period");
    while (obs.size() > 0) begin
      o = obs.pop_front(); e = exp_q.pop_front(); n = nm.pop_front();
      checks++;
      if (o !== e) begin errors++; $display("FAIL %s got %0h want %0h", n, o, e); end
    end
  endtask

  task automatic test_blink();
    logic [31:0] obs[$];
    string       nm[$];
    logic [31:0] r, o, e;
    string       n;
    led_in = 8'hFF;
    reg_write(2'd1, 32'hFF);
    reg_write(2'd2, 32'd1);
    reg_write(2'd3, 32'd2);
    restart(32'h3);
    exp_q.push_back(32'd1536); exp_q.push_back(32'hFF); exp_q.push_back(32'h00); exp_q.push_back(32'h3);
    capture(1600, 0, 2'd0, 32'd0);
    obs.push_back(count_eq(1, 1536, 8'hFF)); nm.push_back("blink_phase1_on");
    obs.push_back({24'd0, cap[1536]});       nm.push_back("blink_last_on");
    obs.push_back({24'd0, cap[1537]});       nm.push_back("blink_first_off");
    reg_read(2'd0, r); obs.push_back(r);     nm.push_back("blink_ctrl_phase0");
    exp_q.push_back(32'd1536); exp_q.push_back(32'h00); exp_q.push_back(32'hFF); exp_q.push_back(32'h103);
    capture(1500, 0, 2'd0, 32'd0);
    obs.push_back(count_eq(1537, 3072, 8'h00)); nm.push_back("blink_phase0_off");
    obs.push_back({24'd0, cap[3072]});          nm.push_back("blink_last_off");
    obs.push_back({24'd0, cap[3073]});          nm.push_back("blink_back_on");
    reg_read(2'd0, r); obs.push_back(r);        nm.push_back("blink_ctrl_phase1");
    while (obs.size() > 0) begin
      o = obs.pop_front(); e = exp_q.pop_front(); n = nm.pop_front();
      checks++;
      if (o !== e) begin errors++; $display("FAIL %s got %0h want %0h", n, o, e); end
    end
  endtask

  initial begin
    cap_n = 0;
    test_reset();
    test_passthrough();
    test_pwm();
    test_duty_change();
    test_extremes();
    test_blink();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
